muldiv: RTL and testbench

Multi-cycle multiply/divide unit beside the EX-stage ALU of the P6 pipelined CPU. It takes the same forwarded operands that feed the ALU, runs MIPS mult/multu/div/divu with fixed latency, and owns the architectural HI and LO registers. It drives a busy flag that the hazard unit uses to stall mult/div/mfhi/mflo/mthi/mtlo instructions in D.

---
 rtl/muldiv.sv | 121 ++++++++++++
 tb/tb_muldiv.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// rtl/muldiv.sv - fixed-latency MIPS mult/multu/div/divu unit owning the HI/LO registers
module muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] numa,
  input  logic [31:0] numb,
  input  logic [2:0]  mdop,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   tmp_hi, tmp_lo;
  logic          tmp_skip;

  logic          is_mul, is_div, sdiv, finish;
  logic [63:0]   sprod, uprod;
  logic [31:0]   abs_a, abs_b, mag_q, mag_r, quo, rem;
  logic [31:0]   res_hi, res_lo;
  logic          res_skip;

  always_comb begin
    is_mul = (mdop == 3'd1) || (mdop == 3'd2);
    is_div = (mdop == 3'd3) || (mdop == 3'd4);
    sdiv   = (mdop == 3'd3);

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    sprod = {{32{numa[31]}}, numa} * {{32{numb[31]}}, numb};
    uprod = {32'd0, numa} * {32'd0, numb};

    // Signed divide on magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
    abs_a = (sdiv && numa[31]) ? (~numa + 32'd1) : numa;
    abs_b = (sdiv && numb[31]) ? (~numb + 32'd1) : numb;
    mag_q = 32'd0;
    mag_r = 32'd0;
    if (numb != 32'd0) begin
      mag_q = abs_a / abs_b;
      mag_r = abs_a % abs_b;
    end
    quo = (sdiv && (numa[31] ^ numb[31])) ? (~mag_q + 32'd1) : mag_q;
    rem = (sdiv && numa[31]) ? (~mag_r + 32'd1) : mag_r;

    res_hi   = 32'd0;
    res_lo   = 32'd0;
    res_skip = 1'b0;
    case (mdop)
      3'd1: {res_hi, res_lo} = sprod;
      3'd2: {res_hi, res_lo} = uprod;
      3'd3, 3'd4: begin
        res_hi   = rem;
        res_lo   = quo;
        res_skip = (numb == 32'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    start     = 1'b0;
    finish    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        start = is_mul || is_div;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        finish = (cnt == CW'(1));
        if (finish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      tmp_hi   <= 32'd0;
      tmp_lo   <= 32'd0;
      tmp_skip <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        busy     <= 1'b1;
        cnt      <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        tmp_hi   <= res_hi;
        tmp_lo   <= res_lo;
        tmp_skip <= res_skip;
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
        if (finish) begin
          busy <= 1'b0;
          if (!tmp_skip) begin
            hi <= tmp_hi;
            lo <= tmp_lo;
          end
        end
      end else if (mdop == 3'd5) begin
        hi <= numa;
      end else if (mdop == 3'd6) begin
        lo <= numa;
      end
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - randomized self-checking bench for muldiv against an arithmetic reference model
module tb_muldiv;

  logic        clk;
  logic        reset;
  logic [31:0] numa, numb;
  logic [2:0]  mdop;
  logic        start, busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  muldiv dut (
    .clk  (clk),
    .reset(reset),
    .numa (numa),
    .numb (numb),
    .mdop (mdop),
    .start(start),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected HI/LO after op and the number of busy cycles it should produce.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] eh, inout logic [31:0] el, output int nb);
    longint          sp, q, r;
    longint unsigned up;
    nb = 0;
    case (op)
      3'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {eh, el} = sp;
        nb = 5;
      end
      3'd2: begin
        up = longint'(a) * longint'(b);
        {eh, el} = up;
        nb = 5;
      end
      3'd3: begin
        if (b != 0) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          el = q[31:0];
          eh = r[31:0];
        end
        nb = 10;
      end
      3'd4: begin
        if (b != 0) begin
          el = a / b;
          eh = a % b;
        end
        nb = 10;
      end
      3'd5: eh = a;
      3'd6: el = a;
      default: ;
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge of the first idle cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] busy_op);
    int nb, cyc;
    logic [31:0] eh, el;
    eh = m_hi;
    el = m_lo;
    model(op, a, b, eh, el, nb);
    mdop = op;
    numa = a;
    numb = b;
    #1;
    check("start", start, (op >= 3'd1 && op <= 3'd4));
    @(negedge clk);
    cyc = 0;
    while (busy && cyc < 20) begin
      check("hold_hi", hi, m_hi);
      check("hold_lo", lo, m_lo);
      check("start_busy", start, 1'b0);
      mdop = busy_op;
      numa = $urandom;
      numb = $urandom;
      cyc++;
      @(negedge clk);
    end
    mdop = 3'd0;
    check("busy_cycles", cyc, nb);
    m_hi = eh;
    m_lo = el;
    check("hi", hi, eh);
    check("lo", lo, el);
  endtask

  initial begin
    logic [2:0]  op, bop;
    logic [31:0] a, b;
    int          r;

    reset = 1'b1;
    mdop  = 3'd0;
    numa  = 32'd0;
    numb  = 32'd0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_start", start, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, 3'd0);
    check("mult_hi_k", hi, 32'hFFFFFFFF);
    check("mult_lo_k", lo, 32'hFFFFFFFE);
    run_op(3'd2, 32'hFFFFFFFF, 32'h00000002, 3'd0);
    check("multu_hi_k", hi, 32'h00000001);
    check("multu_lo_k", lo, 32'hFFFFFFFE);
    run_op(3'd3, 32'hFFFFFFF9, 32'h00000002, 3'd0);
    check("div_lo_k", lo, 32'hFFFFFFFD);
    check("div_hi_k", hi, 32'hFFFFFFFF);
    run_op(3'd4, 32'd7, 32'd2, 3'd0);
    check("divu_lo_k", lo, 32'd3);
    check("divu_hi_k", hi, 32'd1);
    run_op(3'd5, 32'h12345678, 32'd0, 3'd0);
    run_op(3'd4, 32'd99, 32'd0, 3'd0);
    check("divz_hi_k", hi, 32'h12345678);
    check("divz_lo_k", lo, 32'd3);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 3'd0);
    check("ovf_lo_k", lo, 32'h80000000);
    check("ovf_hi_k", hi, 32'd0);
    run_op(3'd1, 32'd3, 32'd4, 3'd6);
    check("mtlo_ign_k", lo, 32'h0000000C);
    run_op(3'd6, 32'hAAAA0000, 32'd0, 3'd0);
    check("mtlo_k", lo, 32'hAAAA0000);

    // Reset in the fourth busy cycle of a divide.
    mdop = 3'd3;
    numa = 32'd1000;
    numb = 32'd7;
    @(negedge clk);
    mdop = 3'd0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    #2;
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (12) begin
      @(negedge clk);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_hi", hi, 32'd0);
      check("post_rst_lo", lo, 32'd0);
    end

    for (int i = 0; i < 300; i++) begin
      op  = 3'($urandom_range(0, 7));
      bop = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      r   = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      else if (r == 1) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end else if (r == 2) b = 32'($urandom_range(1, 5));
      else if (r == 3) b = -32'($urandom_range(1, 5));
      run_op(op, a, b, bop);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
